sipo_deser: RTL and testbench
=============================

// Module: sipo_deser
// PURPOSE
//  Serial-in/parallel-out deserializer; receive-side counterpart of the PISO shifter in the NVM reader path.
//  Shifts WIDTH bits from D_In on Write-qualified clocks after a Start pulse, then presents the word on D_Out.
//  The word is held with a Valid/Ack handshake. A sticky Overrun flag reports a word lost to an unacknowledged predecessor.
// PARAMETERS
//  WIDTH      8   bits per frame/word (>=2)
//  MSB_FIRST  1   1: first received bit lands in D_Out[WIDTH-1]; 0: first bit lands in D_Out[0]
// PORTS
//  CLK      in   1      system clock, all state on rising edge
//  RST      in   1      synchronous reset, active-high
//  Start    in   1      frame start; arms/restarts deserializer, discards partial frame
//  Write    in   1      shift enable; D_In sampled on CLK edge when Write=1 and frame active
//  D_In     in   1      serial data bit
//  Ack      in   1      consumer accepts D_Out while Valid=1
//  ClrErr   in   1      clears Overrun
//  D_Out    out  WIDTH  last completed word (held until next completed word is accepted into it)
//  Valid    out  1      D_Out holds an unacknowledged word
//  Busy     out  1      frame active (state SHIFT)
//  Overrun  out  1      sticky: completed word dropped because Valid=1 and Ack=0
// BEHAVIOUR
//  Reset (RST=1 at edge, overrides all inputs): state=IDLE, bit count=0, shift reg=0, D_Out=0, Valid=0, Busy=0, Overrun=0.
//  FSM states: IDLE, SHIFT.
//   IDLE: Write ignored. Start=1 -> SHIFT, count=0. Start and Write in the same cycle: D_In is NOT sampled.
//   SHIFT: Write=1 -> shift D_In into the shift reg, count+1. Write=0 -> hold.
//    Start=1 in SHIFT (with or without Write) -> count=0, partial bits discarded, stay SHIFT, no bit sampled.
//    The Write that takes in bit WIDTH completes the frame: state -> IDLE, count -> 0.
//  Count width: $clog2(WIDTH+1). Count never exceeds WIDTH-1 at rest; no wrap.
//  Completion edge: the assembled word includes the bit sampled on that same edge.
//   Valid=0, or Valid=1 and Ack=1 -> D_Out<=word, Valid<=1. Word visible the cycle after the last Write.
//   Valid=1 and Ack=0 -> word dropped, D_Out/Valid unchanged, Overrun<=1.
//  Ack=1 with Valid=1 and no completion -> Valid<=0; D_Out keeps its value. Ack while Valid=0 is ignored.
//  Overrun: set per the rule above, cleared by ClrErr or RST. If set and ClrErr occur on the same edge, set wins.
//  Busy = (state==SHIFT), registered.
//  Bit order: MSB_FIRST=1 -> shift left, new bit enters LSB. MSB_FIRST=0 -> shift right, new bit enters MSB.
//  Latency: Start to first sample is >=1 cycle. Min frame = 1 Start cycle + WIDTH Write cycles. Valid rises 1 cycle after the last bit.
//  RST mid-frame aborts the frame and clears held data; no partial word is ever presented.
// TESTING
//  1 Reset: RST=1 for 2 cycles with Start/Write toggling -> D_Out=0x00, Valid=0, Busy=0, Overrun=0.
//  2 MSB_FIRST=1: Start, then Write on 8 cycles with bits 1,0,1,0,0,1,0,1 -> D_Out=0xA5, Valid=1 the next cycle, Busy=0.
//  3 Gapped Write: same 8 bits with Write=0 on 3 interleaved cycles -> D_Out=0xA5. Valid only after the 8th bit.
//  4 Restart: Start, 4 bits 1111, Start, then 8 bits of 0x3C -> D_Out=0x3C, no trace of the partial frame.
//  5 Overrun: 0x11 received and not acked, then 0x22 received -> D_Out=0x11, Overrun=1. Ack -> Valid=0. ClrErr -> Overrun=0.
//  6 Ack on the completion edge: 0x11 held, Ack on the same cycle the last bit of 0x22 arrives -> D_Out=0x22, Valid=1, Overrun=0.

Source files
------------

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a Valid/Ack hold register and a sticky
// Overrun flag for words lost while the previous word was still unacknowledged.
module sipo_deser #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic             Write,
   input  logic             D_In,
   input  logic             Ack,
   input  logic             ClrErr,
   output logic [WIDTH-1:0] D_Out,
   output logic             Valid,
   output logic             Busy,
   output logic             Overrun
);

   localparam int unsigned    CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   logic [WIDTH-1:0] shift_in;
   logic             done;
   logic             drop;

   // Incoming word with the current bit included, so completion can use it directly.
   always_comb begin
      if (MSB_FIRST) begin
         shift_in = {shreg_q[WIDTH-2:0], D_In};
      end else begin
         shift_in = {D_In, shreg_q[WIDTH-1:1]};
      end
   end

   // Frame sequencing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               state_d = StShift;
               cnt_d   = '0;
               shreg_d = '0;
            end
         end
         StShift: begin
            if (Start) begin
               cnt_d   = '0;
               shreg_d = '0;
            end else if (Write) begin
               shreg_d = shift_in;
               if (cnt_q == LastIdx) begin
                  done    = 1'b1;
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Output hold register and error flag
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      drop    = 1'b0;
      if (done) begin
         if (!valid_q || Ack) begin
            dout_d  = shift_in;
            valid_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else if (valid_q && Ack) begin
         valid_d = 1'b0;
      end
      // A drop on the same edge as ClrErr must still be reported.
      if (drop) begin
         overrun_d = 1'b1;
      end else if (ClrErr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         shreg_q   <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign D_Out   = dout_q;
   assign Valid   = valid_q;
   assign Busy    = (state_q == StShift);
   assign Overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: a frame-level model predicts accepted words and flags;
// a monitor pops expected words whenever the DUT presents a new one.
module tb_sipo_deser;

   localparam int unsigned WIDTH = 8;

   logic             CLK = 1'b0;
   logic             RST, Start, Write, D_In, Ack, ClrErr;
   logic [WIDTH-1:0] D_Out;
   logic             Valid, Busy, Overrun;

   sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Write(Write), .D_In(D_In), .Ack(Ack),
      .ClrErr(ClrErr), .D_Out(D_Out), .Valid(Valid), .Busy(Busy), .Overrun(Overrun)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state (post-edge view)
   bit               m_active   = 1'b0;
   bit               exp_valid  = 1'b0;
   bit               exp_ovr    = 1'b0;
   logic [WIDTH-1:0] exp_dout   = '0;
   bit               frame[$];
   logic [WIDTH-1:0] sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] assemble();
      logic [WIDTH-1:0] w = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (frame[i]) w = w + (WIDTH'(1) << (WIDTH - 1 - i));
      end
      return w;
   endfunction

   // Predict the effect of the coming clock edge.
   task automatic model_step(input bit rst, st, wr, d, ak, cl);
      bit done = 1'b0;
      bit setov = 1'b0;
      logic [WIDTH-1:0] w = '0;
      if (rst) begin
         frame.delete();
         m_active  = 1'b0;
         exp_valid = 1'b0;
         exp_ovr   = 1'b0;
         exp_dout  = '0;
         return;
      end
      if (st) begin
         m_active = 1'b1;
         frame.delete();
      end else if (m_active && wr) begin
         frame.push_back(d);
         if (frame.size() == WIDTH) begin
            w = assemble();
            done = 1'b1;
            m_active = 1'b0;
            frame.delete();
         end
      end
      if (done) begin
         if (!exp_valid || ak) begin
            exp_valid = 1'b1;
            exp_dout  = w;
            sb_q.push_back(w);
         end else begin
            setov = 1'b1;
         end
      end else if (exp_valid && ak) begin
         exp_valid = 1'b0;
      end
      if (setov) exp_ovr = 1'b1;
      else if (cl) exp_ovr = 1'b0;
   endtask

   task automatic cyc(input bit rst, st, wr, d, ak, cl);
      @(negedge CLK);
      RST = rst; Start = st; Write = wr; D_In = d; Ack = ak; ClrErr = cl;
      model_step(rst, st, wr, d, ak, cl);
   endtask

   task automatic send(input logic [WIDTH-1:0] w, input int gaps, input bit ack_last,
                       input bit clr_last);
      int g = gaps;
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < WIDTH; i++) begin
         if (g > 0 && (i % 2) == 1) begin
            cyc(0, 0, 0, 1, 0, 0);
            g--;
         end
         cyc(0, 0, 1, w[WIDTH-1-i], ack_last && (i == WIDTH - 1), clr_last && (i == WIDTH - 1));
      end
   endtask

   // Monitor: compares flags every cycle; pops the scoreboard on each new word.
   initial begin
      bit prev_valid = 1'b0;
      logic [WIDTH-1:0] w;
      forever begin
         @(posedge CLK);
         #1;
         check("valid", 32'(Valid), 32'(exp_valid));
         check("busy", 32'(Busy), 32'(m_active));
         check("overrun", 32'(Overrun), 32'(exp_ovr));
         check("d_out_held", 32'(D_Out), 32'(exp_dout));
         if (Valid && (!prev_valid || Ack)) begin
            if (sb_q.size() == 0) begin
               check("unexpected_word", 32'(D_Out), 32'hFFFF_FFFF);
            end else begin
               w = sb_q.pop_front();
               check("word", 32'(D_Out), 32'(w));
            end
         end
         prev_valid = Valid;
      end
   end

   initial begin
      RST = 1'b1; Start = 1'b0; Write = 1'b0; D_In = 1'b0; Ack = 1'b0; ClrErr = 1'b0;
      // Reset with Start/Write toggling
      cyc(1, 1, 1, 1, 0, 0);
      cyc(1, 0, 1, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0);
      // 0xA5, contiguous then gapped
      send(8'hA5, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      send(8'hA5, 3, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      // Restart discards partial frame
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 0);
      send(8'h3C, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      // Overrun, Ack, ClrErr
      send(8'h11, 0, 0, 0);
      send(8'h22, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1);
      // Ack on the completion edge replaces the held word
      send(8'h11, 0, 0, 0);
      send(8'h22, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      // Overrun set wins over ClrErr on the same edge
      send(8'h5A, 0, 0, 0);
      send(8'hC3, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 1);
      // Start with Write in idle samples nothing; Ack with Valid=0 is ignored
      cyc(0, 1, 1, 1, 1, 0);
      for (int i = 0; i < WIDTH; i++) cyc(0, 0, 1, i[0], 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      // Reset mid-frame with a word held
      send(8'h77, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0);
      cyc(1, 0, 1, 1, 0, 0);
      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 6), 1'($urandom), ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) == 0));
      end
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      @(posedge CLK);
      #2;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
